// File: rtl/fetch_scheduler_if.sv
// Handshake bundle between fetch_scheduler, its column fetcher and consumer.
// master = scheduler side, slave = fetcher/consumer/host side.
interface fetch_scheduler_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int LID_W  = 2
);
   logic                    start;
   logic [CNT_W-1:0]        total;
   logic [LANES-1:0]        lane_mask;
   logic [LANES-1:0]        fetch_read;
   logic [LANES*DATA_W-1:0] fetch_data;
   logic [LANES-1:0]        fetch_empty;
   logic [DATA_W-1:0]       out_data;
   logic [LID_W-1:0]        out_lane;
   logic                    out_valid;
   logic                    out_ready;
   logic                    busy;
   logic                    done;
   logic [CNT_W-1:0]        remaining;

   modport master (
      input  start, total, lane_mask,
      input  fetch_data, fetch_empty, out_ready,
      output fetch_read, out_data, out_lane,
      output out_valid, busy, done, remaining
   );

   modport slave (
      output start, total, lane_mask,
      output fetch_data, fetch_empty, out_ready,
      input  fetch_read, out_data, out_lane,
      input  out_valid, busy, done, remaining
   );
endinterface

// File: rtl/fetch_scheduler.sv
// Round-robin scheduler merging fetcher lanes into one registered
// valid/ready stream; issues a job of 'total' words per start.
module fetch_scheduler #(
   parameter int LANES  = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int LID_W  = 2
) (
   input  logic clk,
   input  logic rst,
   fetch_scheduler_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [LANES-1:0]    mask_q;
   logic [CNT_W-1:0]    remaining_q;
   logic [LID_W-1:0]    rr_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [LID_W-1:0]    out_lane_q;
   logic                out_valid_q;
   logic                done_q;

   logic [LANES-1:0]    elig;
   logic                slot_free;
   logic                found_d;
   logic [LID_W-1:0]    gnt_idx_d;
   logic [LANES-1:0]    gnt_oh_d;
   logic                grant_d;
   int                  idx;

   assign slot_free = !out_valid_q || bus.out_ready;
   assign elig      = ~bus.fetch_empty & mask_q;

   // Search starts one past the last granted lane, wrapping around.
   always_comb begin
      found_d   = 1'b0;
      gnt_idx_d = '0;
      idx       = 0;
      for (int k = 1; k <= LANES; k++) begin
         idx = (int'(rr_q) + k) % LANES;
         if (!found_d && elig[idx]) begin
            found_d   = 1'b1;
            gnt_idx_d = LID_W'(idx);
         end
      end
   end

   // Gating with rst keeps the fetcher untouched on the reset edge.
   assign grant_d = !rst && (state_q == RUN) &&
                    (remaining_q != '0) &&
                    slot_free && found_d;

   always_comb begin
      gnt_oh_d = '0;
      if (grant_d) gnt_oh_d[gnt_idx_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         remaining_q <= '0;
         rr_q        <= LID_W'(LANES - 1);
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (grant_d) begin
            out_data_q  <= bus.fetch_data[gnt_idx_d*DATA_W +: DATA_W];
            out_lane_q  <= gnt_idx_d;
            out_valid_q <= 1'b1;
            rr_q        <= gnt_idx_d;
            remaining_q <= remaining_q - CNT_W'(1);
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mask_q      <= bus.lane_mask;
                  remaining_q <= bus.total;
                  if (bus.total == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (grant_d && remaining_q == CNT_W'(1))
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (!out_valid_q || bus.out_ready) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.fetch_read = gnt_oh_d;
   assign bus.out_data   = out_data_q;
   assign bus.out_lane   = out_lane_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
   assign bus.done       = done_q;
   assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed bench for fetch_scheduler: per-cycle strobe checks plus a
// scoreboard that pairs every accepted output word with its expected value.
module tb_fetch_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fetch_scheduler_if #(.LANES(4), .DATA_W(16), .CNT_W(16), .LID_W(2)) bus ();

   fetch_scheduler #(.LANES(4), .DATA_W(16), .CNT_W(16), .LID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   logic [11:0] cnt [4];
   logic [11:0] exp_cnt [4];
   logic [17:0] exp_q [$];
   logic [15:0] held;

   // Fetcher model: lane word = {lane id, per-lane pop count}
   always_comb begin
      bus.fetch_data = '0;
      for (int i = 0; i < 4; i++)
         bus.fetch_data[i*16 +: 16] = {4'(i), cnt[i]};
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (bus.fetch_read[i]) cnt[i] <= cnt[i] + 12'd1;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int l);
      logic [1:0] ln;
      ln = l[1:0];
      exp_q.push_back({ln, 4'(l), exp_cnt[l]});
      exp_cnt[l] = exp_cnt[l] + 12'd1;
   endtask

   // Monitor samples after the stimulus has settled for this half cycle.
   always @(negedge clk) begin
      logic [17:0] e;
      #2;
      if (mon_en && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", {14'd0, bus.out_lane, bus.out_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("out_word", {14'd0, bus.out_lane, bus.out_data}, {14'd0, e});
         end
      end
   end

   task automatic rd(input string name, input logic [3:0] exp);
      @(negedge clk);
      #1 chk(name, {28'd0, bus.fetch_read}, {28'd0, exp});
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         cnt[i]     = '0;
         exp_cnt[i] = '0;
      end
      bus.start       = 1'b1;
      bus.total       = 16'd5;
      bus.lane_mask   = 4'hF;
      bus.fetch_empty = 4'h0;
      bus.out_ready   = 1'b1;

      // Reset held with start asserted
      @(posedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         chk("rst_read", {28'd0, bus.fetch_read}, 32'd0);
         chk("rst_flags", {29'd0, bus.out_valid, bus.busy, bus.done}, 32'd0);
      end
      chk("rst_remaining", {16'd0, bus.remaining}, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Full round-robin
      @(negedge clk);
      bus.start = 1'b1;
      bus.total = 16'd8;
      for (int k = 0; k < 8; k++) push(k % 4);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("rr_read0", {28'd0, bus.fetch_read}, 32'd1);
      for (int k = 1; k < 8; k++)
         rd("rr_read", 4'(1 << (k % 4)));
      @(negedge clk);
      #1 chk("rr_drain", {29'd0, bus.fetch_read == 0, bus.busy, bus.done}, 32'b110);
      @(negedge clk);
      #1 chk("rr_done", {31'd0, bus.done}, 32'd1);
      chk("rr_remaining", {16'd0, bus.remaining}, 32'd0);
      @(negedge clk);
      #1 chk("rr_idle", {30'd0, bus.busy, bus.done}, 32'd0);

      // Zero-length job
      @(negedge clk);
      bus.start = 1'b1;
      bus.total = 16'd0;
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("zero_done", {29'd0, bus.fetch_read == 0, bus.busy, bus.done}, 32'b101);
      rd("zero_read", 4'd0);
      chk("zero_clear", {30'd0, bus.busy, bus.done}, 32'd0);

      // Backpressure
      @(negedge clk);
      bus.start = 1'b1;
      bus.total = 16'd4;
      held = {4'd0, exp_cnt[0]};
      for (int k = 0; k < 4; k++) push(k);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("bp_read0", {28'd0, bus.fetch_read}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         #1;
         chk("bp_read", {28'd0, bus.fetch_read}, 32'd0);
         chk("bp_hold", {13'd0, bus.out_valid, bus.out_lane, bus.out_data},
             {13'd0, 1'b1, 2'd0, held});
         chk("bp_remaining", {16'd0, bus.remaining}, 32'd3);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 chk("bp_resume", {28'd0, bus.fetch_read}, 32'd2);
      rd("bp_read", 4'd4);
      rd("bp_read", 4'd8);
      rd("bp_drain", 4'd0);
      @(negedge clk);
      #1 chk("bp_done", {31'd0, bus.done}, 32'd1);

      // Mask and empty skipping
      @(negedge clk);
      bus.start       = 1'b1;
      bus.total       = 16'd6;
      bus.lane_mask   = 4'b1100;
      bus.fetch_empty = 4'b0100;
      push(3); push(3); push(2); push(3); push(2); push(3);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("mask_read0", {28'd0, bus.fetch_read}, 32'd8);
      rd("mask_read1", 4'd8);
      @(negedge clk);
      bus.fetch_empty = 4'b0000;
      #1 chk("mask_wake", {28'd0, bus.fetch_read}, 32'd4);
      rd("mask_alt", 4'd8);
      rd("mask_alt", 4'd4);
      rd("mask_alt", 4'd8);
      rd("mask_drain", 4'd0);
      @(negedge clk);
      #1 chk("mask_done", {31'd0, bus.done}, 32'd1);
      bus.lane_mask = 4'hF;

      // Reset in the middle of a job
      @(negedge clk);
      bus.start = 1'b1;
      bus.total = 16'd10;
      push(0); push(1); push(2);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("mid_read0", {28'd0, bus.fetch_read}, 32'd1);
      rd("mid_read1", 4'd2);
      rd("mid_read2", 4'd4);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("mid_rst_read", {28'd0, bus.fetch_read}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_flags", {29'd0, bus.out_valid, bus.busy, bus.done}, 32'd0);
      chk("mid_rst_out", {14'd0, bus.out_lane, bus.out_data}, 32'd0);
      chk("mid_rst_rem", {16'd0, bus.remaining}, 32'd0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.total = 16'd2;
      push(0); push(1);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("post_read0", {28'd0, bus.fetch_read}, 32'd1);
      rd("post_read1", 4'd2);
      rd("post_drain", 4'd0);
      @(negedge clk);
      #1 chk("post_done", {31'd0, bus.done}, 32'd1);

      repeat (3) @(negedge clk);
      #3 chk("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
